// File: rtl/cpri_tx_pkg.sv
// Shared CPRI TX definitions: PRB geometry, tag widths and scheduler states.
package cpri_tx_pkg;
    localparam int RE_PER_PRB = 12;
    localparam int MAX_PRB    = 273;
    localparam int SLOT_W     = 7;
    localparam int SYMB_W     = 4;
    localparam int PRB_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_GAP,
        ST_FLUSH
    } sched_st_t;

    function automatic logic [PRB_W-1:0] clamp_prb(input logic [PRB_W-1:0] n);
        if (n == '0)
            return PRB_W'(1);
        if (n > PRB_W'(MAX_PRB))
            return PRB_W'(MAX_PRB);
        return n;
    endfunction
endpackage

// File: rtl/prb_align_pipe.sv
// Fixed-depth delay line that lines up PRB framing with buffer read data.
module prb_align_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/compress_prb_sched.sv
// Per-symbol PRB scheduler feeding the 4-antenna block compressor.
module compress_prb_sched
    import cpri_tx_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int PRB_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sym_start,
    input  logic [SLOT_W-1:0] i_slot_idx,
    input  logic [SYMB_W-1:0] i_symb_idx,
    input  logic [PRB_W-1:0]  i_num_prb,
    input  logic [15:0]       i_ch_type,
    input  logic [31:0]       i_info,
    input  logic [3:0]        i_buf_rdy,
    output logic [3:0]        o_rd_en,
    output logic [3:0]        o_sel,
    output logic [3:0]        o_sop,
    output logic [3:0]        o_eop,
    output logic [3:0]        o_vld,
    output logic [SLOT_W-1:0] o_slot_idx,
    output logic [SYMB_W-1:0] o_symb_idx,
    output logic [PRB_W-1:0]  o_prb_idx,
    output logic [15:0]       o_ch_type,
    output logic [31:0]       o_info,
    output logic              o_busy,
    output logic              o_sym_done,
    output logic              o_err_start
);
    localparam int RE_W = (RE_PER_PRB > 1) ? $clog2(RE_PER_PRB) : 1;
    localparam logic [RE_W-1:0] RE_LAST  = RE_W'(RE_PER_PRB - 1);
    localparam logic [2:0]      GAP_LAST = 3'(PRB_GAP - 1);
    localparam logic [1:0]      FL_LAST  = 2'(RD_LAT - 1);
    localparam int PIPE_W = 3 + PRB_W;

    sched_st_t         r_state;
    logic [RE_W-1:0]   r_re_cnt;
    logic [PRB_W-1:0]  r_prb_cnt;
    logic [PRB_W-1:0]  r_num_m1;
    logic [2:0]        r_gap_cnt;
    logic [1:0]        r_fl_cnt;
    logic              r_rd_en;
    logic              r_sel;
    logic              r_sop0;
    logic              r_eop0;
    logic [PRB_W-1:0]  r_prb0;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [SLOT_W-1:0] r_slot;
    logic [SYMB_W-1:0] r_symb;
    logic [15:0]       r_ch;
    logic [31:0]       r_info;

    logic              w_accept;
    logic              w_last_re;
    logic              w_fl_done;
    logic              w_burst;
    logic [PRB_W-1:0]  w_num;
    logic [PIPE_W-1:0] w_pipe_q;

    // A start coinciding with o_sym_done is refused like any busy start.
    assign w_accept  = i_sym_start && (r_state == ST_IDLE) && !r_done;
    assign w_last_re = (r_re_cnt == RE_LAST);
    assign w_fl_done = (r_state == ST_FLUSH) && (r_fl_cnt == FL_LAST);
    assign w_burst   = (r_state == ST_BURST);
    assign w_num     = clamp_prb(i_num_prb);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_re_cnt  <= '0;
            r_prb_cnt <= '0;
            r_num_m1  <= '0;
            r_gap_cnt <= '0;
            r_fl_cnt  <= '0;
            r_rd_en   <= 1'b0;
            r_sel     <= 1'b0;
            r_sop0    <= 1'b0;
            r_eop0    <= 1'b0;
            r_prb0    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_slot    <= '0;
            r_symb    <= '0;
            r_ch      <= '0;
            r_info    <= '0;
        end else begin
            r_rd_en <= w_burst;
            r_sop0  <= w_burst && (r_re_cnt == '0);
            r_eop0  <= w_burst && w_last_re;
            r_prb0  <= w_burst ? r_prb_cnt : '0;
            r_sel   <= (r_state != ST_IDLE);
            r_err   <= i_sym_start && !w_accept;
            r_done  <= w_fl_done;
            if (w_fl_done)
                r_busy <= 1'b0;
            else if (w_accept)
                r_busy <= 1'b1;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_slot    <= i_slot_idx;
                        r_symb    <= i_symb_idx;
                        r_ch      <= i_ch_type;
                        r_info    <= i_info;
                        r_num_m1  <= w_num - PRB_W'(1);
                        r_prb_cnt <= '0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (&i_buf_rdy) begin
                        r_re_cnt <= '0;
                        r_state  <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_last_re) begin
                        r_re_cnt <= '0;
                        if (r_prb_cnt == r_num_m1) begin
                            r_fl_cnt <= '0;
                            r_state  <= ST_FLUSH;
                        end else begin
                            r_prb_cnt <= r_prb_cnt + PRB_W'(1);
                            r_gap_cnt <= '0;
                            r_state   <= (PRB_GAP == 0) ? ST_WAIT : ST_GAP;
                        end
                    end else begin
                        r_re_cnt <= r_re_cnt + RE_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST)
                        r_state <= ST_WAIT;
                    else
                        r_gap_cnt <= r_gap_cnt + 3'd1;
                end
                ST_FLUSH: begin
                    if (r_fl_cnt == FL_LAST)
                        r_state <= ST_IDLE;
                    else
                        r_fl_cnt <= r_fl_cnt + 2'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    prb_align_pipe #(
        .DEPTH (RD_LAT),
        .W     (PIPE_W)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .i_d ({r_sop0, r_eop0, r_rd_en, r_prb0}),
        .o_q (w_pipe_q)
    );

    assign o_rd_en     = {4{r_rd_en}};
    assign o_sel       = {4{r_sel}};
    assign o_sop       = {4{w_pipe_q[PIPE_W-1]}};
    assign o_eop       = {4{w_pipe_q[PIPE_W-2]}};
    assign o_vld       = {4{w_pipe_q[PIPE_W-3]}};
    assign o_prb_idx   = w_pipe_q[PRB_W-1:0];
    assign o_slot_idx  = r_slot;
    assign o_symb_idx  = r_symb;
    assign o_ch_type   = r_ch;
    assign o_info      = r_info;
    assign o_busy      = r_busy;
    assign o_sym_done  = r_done;
    assign o_err_start = r_err;
endmodule

// File: tb/tb_compress_prb_sched.sv
// Scoreboard bench for compress_prb_sched plus an RD_LAT x PRB_GAP sweep.
module tb_compress_prb_sched;
    typedef struct packed {
        logic [8:0] prb;
        logic       sop;
        logic       eop;
    } beat_t;

    localparam logic [6:0]  SLOT_A  = 7'h13;
    localparam logic [3:0]  SYMB_A  = 4'h9;
    localparam logic [15:0] CH_A    = 16'hA5C3;
    localparam logic [31:0] INFO_A  = 32'hDEADBEEF;
    localparam logic [6:0]  SW_SLOT = 7'h2A;
    localparam logic [3:0]  SW_SYMB = 4'h6;
    localparam logic [15:0] SW_CH   = 16'h1234;
    localparam logic [31:0] SW_INFO = 32'hCAFEF00D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  slot = '0;
    logic [3:0]  symb = '0;
    logic [8:0]  num = '0;
    logic [15:0] ch = '0;
    logic [31:0] info = '0;
    logic [3:0]  rdy = '0;
    logic        sw_start = 1'b0;

    logic [3:0]  o_rd_en, o_sel, o_sop, o_eop, o_vld;
    logic [6:0]  o_slot_idx;
    logic [3:0]  o_symb_idx;
    logic [8:0]  o_prb_idx;
    logic [15:0] o_ch_type;
    logic [31:0] o_info;
    logic        o_busy, o_sym_done, o_err_start;

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t sb_q[$];

    always #5 clk = ~clk;

    compress_prb_sched #(.RD_LAT(1), .PRB_GAP(2)) u_dut (
        .clk(clk), .rst(rst), .i_sym_start(start), .i_slot_idx(slot),
        .i_symb_idx(symb), .i_num_prb(num), .i_ch_type(ch), .i_info(info),
        .i_buf_rdy(rdy), .o_rd_en(o_rd_en), .o_sel(o_sel), .o_sop(o_sop),
        .o_eop(o_eop), .o_vld(o_vld), .o_slot_idx(o_slot_idx),
        .o_symb_idx(o_symb_idx), .o_prb_idx(o_prb_idx), .o_ch_type(o_ch_type),
        .o_info(o_info), .o_busy(o_busy), .o_sym_done(o_sym_done),
        .o_err_start(o_err_start)
    );

    for (genvar g = 0; g < 6; g++) begin : g_sw
        localparam int LAT = g / 2 + 1;
        localparam int GP  = (g % 2 == 1) ? 7 : 0;
        logic [3:0]  rd_en, sel, sop, eop, vld;
        logic [8:0]  prb;
        logic [6:0]  s_slot;
        logic [3:0]  s_symb;
        logic [15:0] s_ch;
        logic [31:0] s_info;
        logic        busy, done, err;
        int beats = 0, last_prb = 0, seq_bad = 0, sel_bad = 0;
        int tag_bad = 0, dones = 0, exp_re = 0, exp_prb = 0;
        logic prev_sel = 1'b0, prev_done = 1'b0;

        compress_prb_sched #(.RD_LAT(LAT), .PRB_GAP(GP)) u_sw (
            .clk(clk), .rst(rst), .i_sym_start(sw_start), .i_slot_idx(SW_SLOT),
            .i_symb_idx(SW_SYMB), .i_num_prb(9'd273), .i_ch_type(SW_CH),
            .i_info(SW_INFO), .i_buf_rdy(4'hF), .o_rd_en(rd_en), .o_sel(sel),
            .o_sop(sop), .o_eop(eop), .o_vld(vld), .o_slot_idx(s_slot),
            .o_symb_idx(s_symb), .o_prb_idx(prb), .o_ch_type(s_ch),
            .o_info(s_info), .o_busy(busy), .o_sym_done(done), .o_err_start(err)
        );

        initial forever begin
            @(negedge clk);
            if (vld != 4'h0) begin
                beats++;
                last_prb = int'(prb);
                if (vld != 4'hF || prb != 9'(exp_prb) || sel != 4'hF ||
                    sop != {4{exp_re == 0}} || eop != {4{exp_re == 11}})
                    seq_bad++;
                if (exp_re == 11) begin
                    exp_re = 0;
                    exp_prb++;
                end else begin
                    exp_re++;
                end
            end
            if (!busy && rd_en != 4'h0) seq_bad++;
            if (err || (sel != 4'h0 && (s_slot != SW_SLOT || s_symb != SW_SYMB ||
                s_ch != SW_CH || s_info != SW_INFO)))
                tag_bad++;
            if (prev_sel && sel == 4'h0 && !prev_done) sel_bad++;
            if (done) dones++;
            prev_sel  = sel[0];
            prev_done = done;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_sym(input int n);
        for (int p = 0; p < n; p++)
            for (int r = 0; r < 12; r++)
                sb_q.push_back(beat_t'{prb: 9'(p), sop: (r == 0), eop: (r == 11)});
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_rd_en"}, int'(o_rd_en), 0);
        chk({t, "_sel"}, int'(o_sel), 0);
        chk({t, "_vld"}, int'({o_vld, o_sop, o_eop}), 0);
        chk({t, "_prb"}, int'(o_prb_idx), 0);
        chk({t, "_flags"}, int'({o_busy, o_sym_done, o_err_start}), 0);
        chk({t, "_tags"}, int'({o_slot_idx, o_symb_idx, o_ch_type}), 0);
        chk({t, "_info"}, int'(o_info), 0);
    endtask

    task automatic set_tags(input logic [8:0] n);
        slot = SLOT_A; symb = SYMB_A; ch = CH_A; info = INFO_A; num = n;
    endtask

    task automatic check_sw(input int id, input int beats, input int lastp,
                            input int seqb, input int selb, input int tagb,
                            input int dn);
        chk($sformatf("sw%0d_beats", id), beats, 273 * 12);
        chk($sformatf("sw%0d_last_prb", id), lastp, 272);
        chk($sformatf("sw%0d_seq", id), seqb, 0);
        chk($sformatf("sw%0d_sel", id), selb, 0);
        chk($sformatf("sw%0d_tags", id), tagb, 0);
        chk($sformatf("sw%0d_done", id), dn, 1);
    endtask

    initial begin : mon
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst && o_vld != 4'h0) begin
                if (sb_q.size() == 0) begin
                    chk("vld_unexpected", int'(o_vld), 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat", int'({o_vld, o_sop, o_eop, o_prb_idx}),
                        int'({4'hF, {4{e.sop}}, {4{e.eop}}, e.prb}));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dk, fv, cnt;
        logic hit;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        rdy = 4'hF;
        repeat (2) @(negedge clk);

        // basic: 3 PRBs
        push_sym(3);
        set_tags(9'd3);
        start = 1'b1;
        dk = 0; fv = 0;
        for (int k = 1; k <= 60 && dk == 0; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) chk("basic_sel_k2", int'({o_sel, o_rd_en}), 'hF0);
            if (k == 3) chk("basic_rd_en_k3", int'(o_rd_en), 'hF);
            if (o_vld != 4'h0 && fv == 0) fv = k;
            if (o_sym_done) begin
                dk = k;
                chk("basic_done_flags", int'({o_busy, o_sel}), 'hF);
            end
        end
        chk("basic_first_vld", fv, 4);
        chk("basic_start_to_done", dk + 1, 46);
        #1;
        chk("basic_sb_empty", sb_q.size(), 0);
        chk("basic_tags", int'({o_slot_idx, o_symb_idx, o_ch_type}),
            int'({SLOT_A, SYMB_A, CH_A}));
        chk("basic_info", int'(o_info), int'(INFO_A));
        repeat (3) @(negedge clk);

        // back-pressure after PRB 0
        push_sym(2);
        set_tags(9'd2);
        start = 1'b1;
        dk = 0; cnt = 0;
        for (int k = 1; k <= 60 && dk == 0; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k >= 16 && k <= 26 && o_vld != 4'h0) cnt++;
            if (k == 20) chk("bp_wait_sel", int'({o_sel, o_rd_en}), 'hF0);
            if (k == 25) chk("bp_rd_en_k25", int'(o_rd_en), 0);
            if (k == 26) chk("bp_rd_en_k26", int'(o_rd_en), 'hF);
            if (k == 14) rdy = 4'h0;
            if (k == 24) rdy = 4'hF;
            if (o_sym_done) dk = k;
        end
        chk("bp_vld_while_wait", cnt, 0);
        chk("bp_done_k", dk, 38);
        #1;
        chk("bp_sb_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);

        // start while busy, and start coinciding with done
        push_sym(2);
        set_tags(9'd2);
        start = 1'b1;
        dk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 6) begin
                chk("err_pulse", int'(o_err_start), 1);
                start = 1'b0;
            end
            if (k == 7) chk("err_once", int'(o_err_start), 0);
            if (k == 5) begin
                start = 1'b1; slot = 7'h55; num = 9'd7;
            end
            if (o_sym_done && dk == 0) begin
                dk = k;
                start = 1'b1;
            end else if (dk != 0 && k == dk + 1) begin
                start = 1'b0;
                chk("err_on_done", int'(o_err_start), 1);
                chk("busy_after_err", int'(o_busy), 0);
            end
        end
        chk("bad_done_k", dk, 30);
        chk("bad_tag_kept", int'(o_slot_idx), int'(SLOT_A));
        chk("bad_sb_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);

        // num_prb == 0 behaves as 1
        push_sym(1);
        set_tags(9'd0);
        start = 1'b1;
        dk = 0;
        for (int k = 1; k <= 40 && dk == 0; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (o_sym_done) dk = k;
        end
        chk("zero_done_k", dk, 15);
        #1;
        chk("zero_sb_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);

        // num_prb above MAX_PRB clamps to 273
        push_sym(273);
        set_tags(9'd400);
        start = 1'b1;
        dk = 0;
        for (int k = 1; k <= 5000 && dk == 0; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (o_sym_done) dk = k;
        end
        chk("clamp_done_k", dk, 4095);
        #1;
        chk("clamp_sb_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);

        // async reset during RE 5 of PRB 1
        push_sym(3);
        set_tags(9'd3);
        start = 1'b1;
        hit = 1'b0;
        for (int k = 1; k <= 40 && !hit; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 22) begin
                #2;
                rst = 1'b0;
                #1;
                chk_zero("midrst");
                sb_q.delete();
                hit = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_vld != 4'h0 || o_rd_en != 4'h0) cnt++;
        end
        chk("post_rst_quiet", cnt, 0);
        chk("post_rst_flags", int'({o_busy, o_sel}), 0);

        // RD_LAT x PRB_GAP sweep with 273 PRBs
        sw_start = 1'b1;
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk);
            sw_start = 1'b0;
            if (g_sw[0].dones > 0 && g_sw[1].dones > 0 && g_sw[2].dones > 0 &&
                g_sw[3].dones > 0 && g_sw[4].dones > 0 && g_sw[5].dones > 0)
                break;
        end
        repeat (4) @(negedge clk);
        check_sw(0, g_sw[0].beats, g_sw[0].last_prb, g_sw[0].seq_bad,
                 g_sw[0].sel_bad, g_sw[0].tag_bad, g_sw[0].dones);
        check_sw(1, g_sw[1].beats, g_sw[1].last_prb, g_sw[1].seq_bad,
                 g_sw[1].sel_bad, g_sw[1].tag_bad, g_sw[1].dones);
        check_sw(2, g_sw[2].beats, g_sw[2].last_prb, g_sw[2].seq_bad,
                 g_sw[2].sel_bad, g_sw[2].tag_bad, g_sw[2].dones);
        check_sw(3, g_sw[3].beats, g_sw[3].last_prb, g_sw[3].seq_bad,
                 g_sw[3].sel_bad, g_sw[3].tag_bad, g_sw[3].dones);
        check_sw(4, g_sw[4].beats, g_sw[4].last_prb, g_sw[4].seq_bad,
                 g_sw[4].sel_bad, g_sw[4].tag_bad, g_sw[4].dones);
        check_sw(5, g_sw[5].beats, g_sw[5].last_prb, g_sw[5].seq_bad,
                 g_sw[5].sel_bad, g_sw[5].tag_bad, g_sw[5].dones);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
